// File: rtl/pe_arr_acc.sv
// Multi-channel MAC array: products -> lane sums -> multi-pass accumulator, then
// saturating/ReLU output stage held until the consumer takes it.
module pe_arr_acc #(
  parameter int input_width  = 8,
  parameter int output_width = 20,
  parameter int PE_arr_size  = 9,
  parameter int num_ch       = 4,
  parameter int acc_width    = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_last,
  input  logic [PE_arr_size*input_width-1:0]         ifm_input,
  input  logic [num_ch*PE_arr_size*input_width-1:0]  wgt_input,
  input  logic [num_ch*output_width-1:0]             bias_input,
  input  logic                                       relu_en,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [num_ch*output_width-1:0]             ofm_output,
  output logic [num_ch-1:0]                          sat_flag
);

  localparam int prod_w = 2 * input_width;
  localparam int sum_w  = prod_w + $clog2(PE_arr_size);
  localparam logic signed [acc_width-1:0] out_max =
    (acc_width'(1) << (output_width - 1)) - acc_width'(1);
  localparam logic signed [acc_width-1:0] out_min =
    -(acc_width'(1) << (output_width - 1));

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t state, state_next;
  logic   accept, handshake, first_pend;

  logic                       vld_p0, last_p0, first_p0, relu_p0;
  logic signed [prod_w-1:0]   prod_p0 [num_ch][PE_arr_size];
  logic signed [output_width-1:0] bias_p0 [num_ch];

  logic                       vld_p1, last_p1, first_p1, relu_p1;
  logic signed [sum_w-1:0]    sum_p1  [num_ch];
  logic signed [output_width-1:0] bias_p1 [num_ch];

  logic signed [sum_w-1:0]     lane_sum [num_ch];
  logic signed [acc_width-1:0] acc      [num_ch];
  logic signed [acc_width-1:0] acc_next [num_ch];

  function automatic logic signed [prod_w-1:0] mul(input logic signed [input_width-1:0] a,
                                                  input logic signed [input_width-1:0] b);
    return prod_w'(a) * prod_w'(b);
  endfunction

  function automatic logic clipped(input logic signed [acc_width-1:0] v);
    return (v > out_max) || (v < out_min);
  endfunction

  function automatic logic signed [output_width-1:0] saturate(input logic signed [acc_width-1:0] v);
    if (v > out_max) return out_max[output_width-1:0];
    if (v < out_min) return out_min[output_width-1:0];
    return v[output_width-1:0];
  endfunction

  function automatic logic signed [output_width-1:0] relu(input logic signed [output_width-1:0] x,
                                                          input logic en);
    return (en && x[output_width-1]) ? '0 : x;
  endfunction

  // in_ready is gated by rst_n so it is low throughout reset and rises right after release
  assign in_ready  = rst_n && (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && in_last) state_next = DRAIN;
      DRAIN:   if (vld_p1 && last_p1) state_next = HOLD;
      HOLD:    if (out_ready)         state_next = ACCUM;
      default:                        state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         first_pend <= 1'b1;
    else if (accept)    first_pend <= 1'b0;
    else if (handshake) first_pend <= 1'b1;
  end

  // stage 1: full-precision products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      first_p0 <= 1'b0;
      relu_p0  <= 1'b0;
      for (int c = 0; c < num_ch; c++) begin
        bias_p0[c] <= '0;
        for (int i = 0; i < PE_arr_size; i++) prod_p0[c][i] <= '0;
      end
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        last_p0  <= in_last;
        first_p0 <= first_pend;
        relu_p0  <= relu_en;
        for (int c = 0; c < num_ch; c++) begin
          bias_p0[c] <= bias_input[c*output_width +: output_width];
          for (int i = 0; i < PE_arr_size; i++)
            prod_p0[c][i] <= mul(ifm_input[i*input_width +: input_width],
                                 wgt_input[(c*PE_arr_size+i)*input_width +: input_width]);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < num_ch; c++) begin
      lane_sum[c] = '0;
      for (int i = 0; i < PE_arr_size; i++)
        lane_sum[c] = lane_sum[c] + sum_w'(prod_p0[c][i]);
    end
  end

  // stage 2: per-channel lane sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      first_p1 <= 1'b0;
      relu_p1  <= 1'b0;
      for (int c = 0; c < num_ch; c++) begin
        sum_p1[c]  <= '0;
        bias_p1[c] <= '0;
      end
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        last_p1  <= last_p0;
        first_p1 <= first_p0;
        relu_p1  <= relu_p0;
        for (int c = 0; c < num_ch; c++) begin
          sum_p1[c]  <= lane_sum[c];
          bias_p1[c] <= bias_p0[c];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < num_ch; c++)
      acc_next[c] = (first_p1 ? acc_width'(bias_p1[c]) : acc[c]) + acc_width'(sum_p1[c]);
  end

  // stage 3: accumulate; the last beat also loads the output registers on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofm_output <= '0;
      sat_flag   <= '0;
      for (int c = 0; c < num_ch; c++) acc[c] <= '0;
    end else if (vld_p1) begin
      for (int c = 0; c < num_ch; c++) begin
        acc[c] <= acc_next[c];
        if (last_p1) begin
          ofm_output[c*output_width +: output_width] <= relu(saturate(acc_next[c]), relu_p1);
          sat_flag[c] <= clipped(acc_next[c]);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_arr_acc.sv
// Randomized bench for pe_arr_acc against a plain-arithmetic dot-product/accumulate model.
module tb_pe_arr_acc;
  localparam int IW = 8, OW = 20, PE = 9, NC = 4, AW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, relu_en = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [PE*IW-1:0]    ifm_input = '0;
  logic [NC*PE*IW-1:0] wgt_input = '0;
  logic [NC*OW-1:0]    bias_input = '0;
  logic [NC*OW-1:0]    ofm_output;
  logic [NC-1:0]       sat_flag;

  int n_tests = 0, n_fail = 0;
  int ifm_v [PE];
  int wgt_v [NC][PE];
  int bias_v [NC];
  longint model_acc [NC];
  int exp_ofm [NC];
  logic [NC-1:0] exp_sat;

  always #5 clk = ~clk;

  pe_arr_acc #(.input_width(IW), .output_width(OW), .PE_arr_size(PE), .num_ch(NC),
               .acc_width(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .ifm_input(ifm_input), .wgt_input(wgt_input), .bias_input(bias_input),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .ofm_output(ofm_output), .sat_flag(sat_flag));

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < PE; i++) ifm_input[i*IW +: IW] = IW'(ifm_v[i]);
    for (int c = 0; c < NC; c++) begin
      bias_input[c*OW +: OW] = OW'(bias_v[c]);
      for (int i = 0; i < PE; i++) wgt_input[(c*PE+i)*IW +: IW] = IW'(wgt_v[c][i]);
    end
  endtask

  task automatic scramble();
    ifm_input  = (PE*IW)'({$urandom, $urandom, $urandom});
    wgt_input  = {$urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
    bias_input = (NC*OW)'({$urandom, $urandom, $urandom});
    relu_en    = 1'($urandom);
    in_last    = 1'($urandom);
  endtask

  // reference: dot product per channel, 32-bit wrapping accumulation
  task automatic model_beat(input bit first);
    longint dot;
    for (int c = 0; c < NC; c++) begin
      dot = 0;
      for (int i = 0; i < PE; i++) dot += longint'(ifm_v[i]) * longint'(wgt_v[c][i]);
      model_acc[c] = (first ? longint'(bias_v[c]) : model_acc[c]) + dot;
      model_acc[c] = longint'(int'(model_acc[c]));
    end
  endtask

  task automatic model_result(input bit relu);
    longint hi, lo, v;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    for (int c = 0; c < NC; c++) begin
      v = model_acc[c];
      exp_sat[c] = 1'b0;
      if (v > hi) begin v = hi; exp_sat[c] = 1'b1; end
      else if (v < lo) begin v = lo; exp_sat[c] = 1'b1; end
      if (relu && v < 0) v = 0;
      exp_ofm[c] = int'(v);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < PE; i++) ifm_v[i] = i + 1;
    for (int c = 0; c < NC; c++) begin
      bias_v[c] = (c == 0) ? 1 : rnd(-1000, 1000);
      for (int i = 0; i < PE; i++) wgt_v[c][i] = (c == 0) ? i + 1 : rnd(-128, 127);
    end
  endtask

  // called at a negedge; returns at the negedge following the accepting edge
  task automatic send_beat(input bit last, input bit relu);
    pack_inputs();
    in_valid = 1'b1;
    in_last  = last;
    relu_en  = relu;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic bubble(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (ofm_output !== '0) begin n_fail++; $display("FAIL reset_ofm: got %h want 0", ofm_output); end
    n_tests++; if (sat_flag !== '0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    set_ramp();
    model_beat(1'b1);
    send_beat(1'b1, 1'b0);
    wait_out(cyc);
    model_result(1'b0);
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", cyc); end
    n_tests++; if (ofm_output[0 +: OW] !== 20'd286) begin n_fail++; $display("FAIL single_ch0: got %0d want 286", $signed(ofm_output[0 +: OW])); end
    for (int c = 1; c < NC; c++) begin
      n_tests++;
      if (ofm_output[c*OW +: OW] !== OW'(exp_ofm[c])) begin
        n_fail++; $display("FAIL single_ofm ch%0d: got %0d want %0d", c, $signed(ofm_output[c*OW +: OW]), exp_ofm[c]);
      end
    end
    n_tests++; if (sat_flag !== exp_sat) begin n_fail++; $display("FAIL single_sat: got %b want %b", sat_flag, exp_sat); end
    handshake();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL single_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_two_pass();
    int cyc;
    set_ramp();
    model_beat(1'b1);
    send_beat(1'b0, 1'b0);
    bubble(1);
    model_beat(1'b0);
    send_beat(1'b1, 1'b0);
    wait_out(cyc);
    model_result(1'b0);
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL two_pass_latency: got %0d want 3", cyc); end
    n_tests++; if (ofm_output[0 +: OW] !== 20'd571 || sat_flag[0] !== 1'b0) begin
      n_fail++; $display("FAIL two_pass_ch0: got %0d sat %b want 571 sat 0", $signed(ofm_output[0 +: OW]), sat_flag[0]);
    end
    for (int c = 1; c < NC; c++) begin
      n_tests++;
      if (ofm_output[c*OW +: OW] !== OW'(exp_ofm[c])) begin
        n_fail++; $display("FAIL two_pass_ofm ch%0d: got %0d want %0d", c, $signed(ofm_output[c*OW +: OW]), exp_ofm[c]);
      end
    end
    handshake();
  endtask

  task automatic test_saturation();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < PE; i++) ifm_v[i] = 127;
      for (int c = 0; c < NC; c++) begin
        bias_v[c] = 0;
        for (int i = 0; i < PE; i++) wgt_v[c][i] = (k == 0) ? 127 : -128;
      end
      for (int p = 0; p < 4; p++) send_beat(p == 3, 1'b0);
      wait_out(cyc);
      for (int c = 0; c < NC; c++) begin
        n_tests++;
        if (ofm_output[c*OW +: OW] !== ((k == 0) ? 20'h7FFFF : 20'h80000)) begin
          n_fail++; $display("FAIL saturate k%0d ch%0d: got %0d want %0d", k, c,
                             $signed(ofm_output[c*OW +: OW]), (k == 0) ? 524287 : -524288);
        end
      end
      n_tests++; if (sat_flag !== 4'hF) begin n_fail++; $display("FAIL saturate_flag k%0d: got %b want 1111", k, sat_flag); end
      handshake();
    end
  endtask

  task automatic test_relu();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < PE; i++) ifm_v[i] = -1;
      for (int c = 0; c < NC; c++) begin
        bias_v[c] = 0;
        for (int i = 0; i < PE; i++) wgt_v[c][i] = i + 1;
      end
      send_beat(1'b1, k == 0);
      wait_out(cyc);
      n_tests++;
      if (ofm_output[0 +: OW] !== ((k == 0) ? 20'd0 : OW'(-45))) begin
        n_fail++; $display("FAIL relu k%0d: got %0d want %0d", k, $signed(ofm_output[0 +: OW]), (k == 0) ? 0 : -45);
      end
      n_tests++; if (sat_flag !== 4'h0) begin n_fail++; $display("FAIL relu_sat k%0d: got %b want 0000", k, sat_flag); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [NC*OW-1:0] held;
    set_ramp();
    for (int c = 0; c < NC; c++) bias_v[c] = rnd(-5000, 5000);
    model_beat(1'b1);
    send_beat(1'b1, 1'b0);
    wait_out(cyc);
    model_result(1'b0);
    held = ofm_output;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      scramble();
      @(negedge clk);
      n_tests++;
      if (ofm_output !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL backpressure cyc%0d: got ofm=%h ready=%b valid=%b want ofm=%h ready=0 valid=1",
                           n, ofm_output, in_ready, out_valid, held);
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (ofm_output[NC*OW-1 -: OW] !== OW'(exp_ofm[NC-1])) begin
      n_fail++; $display("FAIL backpressure_value: got %0d want %0d", $signed(ofm_output[NC*OW-1 -: OW]), exp_ofm[NC-1]);
    end
    handshake();
    set_ramp();
    send_beat(1'b1, 1'b0);
    wait_out(cyc);
    n_tests++; if (ofm_output[0 +: OW] !== 20'd286) begin n_fail++; $display("FAIL backpressure_next: got %0d want 286", $signed(ofm_output[0 +: OW])); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_ramp();
    send_beat(1'b0, 1'b0);
    bubble(1);
    rst_n = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got ready=%b valid=%b want 0/0", in_ready, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    set_ramp();
    model_beat(1'b1);
    send_beat(1'b1, 1'b0);
    wait_out(cyc);
    model_result(1'b0);
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL midreset_latency: got %0d want 3", cyc); end
    n_tests++; if (ofm_output[0 +: OW] !== 20'd286) begin n_fail++; $display("FAIL midreset_ch0: got %0d want 286", $signed(ofm_output[0 +: OW])); end
    // reset while holding a result drops it
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || ofm_output !== '0) begin n_fail++; $display("FAIL holdreset: got valid=%b ofm=%h want 0/0", out_valid, ofm_output); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, passes;
    bit relu;
    for (int t = 0; t < 25; t++) begin
      passes = rnd(1, 4);
      relu = 1'($urandom);
      for (int p = 0; p < passes; p++) begin
        for (int i = 0; i < PE; i++) ifm_v[i] = rnd(-128, 127);
        for (int c = 0; c < NC; c++) begin
          bias_v[c] = rnd(-(1 << (OW - 1)), (1 << (OW - 1)) - 1);
          for (int i = 0; i < PE; i++) wgt_v[c][i] = rnd(-128, 127);
        end
        model_beat(p == 0);
        send_beat(p == passes - 1, (p == passes - 1) ? relu : 1'($urandom));
        if (p != passes - 1) bubble(rnd(0, 2));
      end
      wait_out(cyc);
      model_result(relu);
      n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL random_latency t%0d: got %0d want 3", t, cyc); end
      for (int c = 0; c < NC; c++) begin
        n_tests++;
        if (ofm_output[c*OW +: OW] !== OW'(exp_ofm[c])) begin
          n_fail++; $display("FAIL random_ofm t%0d ch%0d: got %0d want %0d", t, c, $signed(ofm_output[c*OW +: OW]), exp_ofm[c]);
        end
      end
      n_tests++; if (sat_flag !== exp_sat) begin n_fail++; $display("FAIL random_sat t%0d: got %b want %b", t, sat_flag, exp_sat); end
      bubble(rnd(0, 3));
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pass();
    test_saturation();
    test_relu();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
